sort_ctrl: RTL

//  Bubble-sort sequencer for the 256x16 distributed RAM in the sort lab top level.

---
 rtl/sort_pkg.sv | 18 +
 rtl/sort_mem_arb.sv | 24 ++
 rtl/sort_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sort sequencer: default RAM geometry and FSM states.
package sort_pkg;

    localparam int unsigned SORT_AW    = 8;
    localparam int unsigned SORT_DW    = 16;
    localparam int unsigned SORT_CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4,
        ST_NEXT = 3'd5,
        ST_DONE = 3'd6
    } sort_state_e;

endpackage

// File: rtl/sort_mem_arb.sv
// RAM port arbiter: the user entry path owns the port while idle, the sorter owns it while busy.
module sort_mem_arb
    import sort_pkg::*;
#(
    parameter int unsigned AW = SORT_AW,
    parameter int unsigned DW = SORT_DW
) (
    input  logic          sel_fsm,
    input  logic [AW-1:0] usr_addr,
    input  logic [DW-1:0] usr_d,
    input  logic          usr_we,
    input  logic [AW-1:0] fsm_a,
    input  logic [DW-1:0] fsm_d,
    input  logic          fsm_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we
);

    assign mem_a  = sel_fsm ? fsm_a  : usr_addr;
    assign mem_d  = sel_fsm ? fsm_d  : usr_d;
    assign mem_we = sel_fsm ? fsm_we : usr_we;

endmodule

// File: rtl/sort_ctrl.sv
// In-place bubble-sort sequencer for an async-read / sync-write RAM.
// Optional sort-duration counter on port cycles when SORT_CYCLE_CNT_EN is defined.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned AW      = SORT_AW,
    parameter int unsigned DW      = SORT_DW,
    parameter bit          DESCEND = 1'b0
) (
    input  logic                  CLK100MHZ,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [AW-1:0]         usr_addr,
    input  logic [DW-1:0]         usr_d,
    input  logic                  usr_we,
    output logic [AW-1:0]         mem_a,
    output logic [DW-1:0]         mem_d,
    output logic                  mem_we,
    input  logic [DW-1:0]         mem_spo,
    output logic                  busy,
    output logic                  fin
`ifdef SORT_CYCLE_CNT_EN
    ,
    output logic [SORT_CNT_W-1:0] cycles
`endif
);

    localparam int unsigned DEPTH = 1 << AW;

    sort_state_e   state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] n_q, n_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic          swapped_q, swapped_d;
    logic          busy_q, busy_d;
    logic          fin_q, fin_d;

    logic [AW-1:0] i_inc;
    logic          swap_c;
    logic [AW-1:0] fsm_a;
    logic [DW-1:0] fsm_d;
    logic          fsm_we;

    assign i_inc  = i_q + AW'(1);
    // Strict compare keeps equal keys in place.
    assign swap_c = DESCEND ? (a_q < mem_spo) : (a_q > mem_spo);

    // Next-state, datapath and sorter-side RAM port.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        n_d       = n_q;
        a_d       = a_q;
        b_d       = b_q;
        swapped_d = swapped_q;
        fsm_a     = i_q;
        fsm_d     = b_q;
        fsm_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RD0;
                    i_d       = '0;
                    n_d       = AW'(DEPTH - 1);
                    swapped_d = 1'b0;
                end
            end
            ST_RD0: begin
                a_d     = mem_spo;
                state_d = ST_RD1;
            end
            ST_RD1: begin
                fsm_a   = i_inc;
                b_d     = mem_spo;
                state_d = swap_c ? ST_WR0 : ST_NEXT;
            end
            ST_WR0: begin
                fsm_d   = b_q;
                fsm_we  = 1'b1;
                state_d = ST_WR1;
            end
            ST_WR1: begin
                fsm_a     = i_inc;
                fsm_d     = a_q;
                fsm_we    = 1'b1;
                swapped_d = 1'b1;
                state_d   = ST_NEXT;
            end
            ST_NEXT: begin
                if (i_inc < n_q) begin
                    i_d     = i_inc;
                    state_d = ST_RD0;
                end else if (!swapped_q || (n_q == AW'(1))) begin
                    state_d = ST_DONE;
                end else begin
                    n_d       = n_q - AW'(1);
                    i_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = ST_RD0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        fin_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK100MHZ or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            n_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            swapped_q <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            n_q       <= n_d;
            a_q       <= a_d;
            b_q       <= b_d;
            swapped_q <= swapped_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
        end
    end

    assign busy = busy_q;
    assign fin  = fin_q;

    sort_mem_arb #(
        .AW (AW),
        .DW (DW)
    ) u_arb (
        .sel_fsm  (busy_q),
        .usr_addr (usr_addr),
        .usr_d    (usr_d),
        .usr_we   (usr_we),
        .fsm_a    (fsm_a),
        .fsm_d    (fsm_d),
        .fsm_we   (fsm_we),
        .mem_a    (mem_a),
        .mem_d    (mem_d),
        .mem_we   (mem_we)
    );

`ifdef SORT_CYCLE_CNT_EN
    logic [SORT_CNT_W-1:0] cycles_q, cycles_d;

    // Cleared on an accepted start, counts every non-idle clock, saturates.
    always_comb begin
        cycles_d = cycles_q;
        if (state_q == ST_IDLE) begin
            if (start) cycles_d = '0;
        end else if (cycles_q != '1) begin
            cycles_d = cycles_q + SORT_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rstn) begin
        if (!rstn) cycles_q <= '0;
        else       cycles_q <= cycles_d;
    end

    assign cycles = cycles_q;
`endif

endmodule
